trigger_burst_gen: RTL and testbench

- Downstream consumer of the periodic trigger generator's single-cycle `trigger` pulse.
- Each accepted trigger starts a burst of PULSES output pulses, each HIGH_CYC cycles wide, separated by LOW_CYC-cycle gaps.
- Reports busy, end-of-burst (done), a completed-burst count and a sticky overrun flag for triggers that arrive while a burst is running.

---
 rtl/trig_pkg.sv | 13 +
 rtl/trigger_burst_gen.sv | 118 +++++++++++
 tb/tb_trigger_burst_gen.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/trig_pkg.sv
// Shared types for the trigger burst generator.
// Burst FSM state encoding and timer width.
package trig_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } burst_state_t;

  localparam int TMR_W = 8;

endpackage

// File: rtl/trigger_burst_gen.sv
// Turns each accepted trigger into a burst of fixed-width pulses.
// Tracks busy, end-of-burst, completed bursts and dropped triggers.
module trigger_burst_gen
  import trig_pkg::*;
#(
  parameter int PULSES   = 3,
  parameter int HIGH_CYC = 2,
  parameter int LOW_CYC  = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trigger,
  input  logic             en,
  input  logic             clr_ovr,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic [CNT_W-1:0] burst_cnt
);

  localparam logic [TMR_W-1:0] HI_LD =
    TMR_W'(HIGH_CYC - 1);
  localparam logic [TMR_W-1:0] LO_LD =
    TMR_W'(LOW_CYC - 1);
  localparam logic [TMR_W-1:0] LAST_IDX =
    TMR_W'(PULSES - 1);

  burst_state_t     state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [TMR_W-1:0] idx_q, idx_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_hi;
  logic             drop;

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, width timer and pulse index
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    last_hi = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trigger && en) begin
          state_d = HIGH;
          tmr_d   = HI_LD;
          idx_d   = '0;
        end
      end
      HIGH: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end else if (idx_q < LAST_IDX) begin
          state_d = LOW;
          tmr_d   = LO_LD;
        end else begin
          state_d = IDLE;
          last_hi = 1'b1;
        end
      end
      LOW: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end else begin
          state_d = HIGH;
          idx_d   = idx_q + 1'b1;
          tmr_d   = HI_LD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the next cycle; a new drop beats a clear
  always_comb begin
    drop    = trigger && (state_q != IDLE);
    pulse_d = (state_d == HIGH);
    busy_d  = (state_d != IDLE);
    done_d  = last_hi;
    cnt_d   = cnt_q + CNT_W'(last_hi);
    ovr_d   = (ovr_q && !clr_ovr) || drop;
  end

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = ovr_q;
  assign burst_cnt = cnt_q;

endmodule

// File: tb/tb_trigger_burst_gen.sv
// Bench for trigger_burst_gen: default and minimal-parameter instances
// checked every cycle against a burst-offset model.
module tb_trigger_burst_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       trigger = 1'b0;
  logic       en = 1'b1;
  logic       clr_ovr = 1'b0;
  logic [1:0] po, bs, dn, ov;
  logic [7:0] bc0, bc1;

  int npass = 0;
  int nchk  = 0;

  int P [2] = '{3, 1};
  int H [2] = '{2, 1};
  int L [2] = '{2, 1};

  bit m_act [2];
  int m_off [2];
  bit m_po  [2];
  bit m_bs  [2];
  bit m_dn  [2];
  bit m_ov  [2];
  int m_cnt [2];

  bit wrapped0 = 0;
  bit wrapped1 = 0;
  logic [7:0] prev0 = 0;
  logic [7:0] prev1 = 0;

  always #5 clk = ~clk;

  trigger_burst_gen u_a (
    .clk(clk), .reset(reset), .trigger(trigger),
    .en(en), .clr_ovr(clr_ovr),
    .pulse_out(po[0]), .busy(bs[0]), .done(dn[0]),
    .overrun(ov[0]), .burst_cnt(bc0)
  );

  trigger_burst_gen #(
    .PULSES(1), .HIGH_CYC(1), .LOW_CYC(1), .CNT_W(8)
  ) u_b (
    .clk(clk), .reset(reset), .trigger(trigger),
    .en(en), .clr_ovr(clr_ovr),
    .pulse_out(po[1]), .busy(bs[1]), .done(dn[1]),
    .overrun(ov[1]), .burst_cnt(bc1)
  );

  task automatic chk(string name, int act, int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, want %0d at %0t",
                  name, act, exp, $time);
  endtask

  function automatic int blen(int k);
    return P[k] * H[k] + (P[k] - 1) * L[k];
  endfunction

  // Model: a burst is a window of blen cycles starting the cycle after
  // acceptance; pulse is high in the first H cycles of each H+L period.
  always @(posedge clk or negedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_act[k] = 0; m_off[k] = 0; m_po[k] = 0;
        m_bs[k] = 0; m_dn[k] = 0; m_ov[k] = 0; m_cnt[k] = 0;
      end else begin
        bit cur;
        cur = m_act[k];
        if (clr_ovr) m_ov[k] = 0;
        if (trigger && cur) m_ov[k] = 1;
        m_dn[k] = 0;
        if (cur) begin
          m_off[k]++;
          if (m_off[k] == blen(k)) begin
            m_act[k] = 0;
            m_dn[k] = 1;
            m_cnt[k] = (m_cnt[k] + 1) % 256;
          end
        end else if (trigger && en) begin
          m_act[k] = 1;
          m_off[k] = 0;
        end
        m_bs[k] = m_act[k];
        m_po[k] = m_act[k] &&
                  ((m_off[k] % (H[k] + L[k])) < H[k]);
      end
    end
  end

  // Per-cycle compare of both instances against the model
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("pulse%0d", k), int'(po[k]), int'(m_po[k]));
      chk($sformatf("busy%0d", k), int'(bs[k]), int'(m_bs[k]));
      chk($sformatf("done%0d", k), int'(dn[k]), int'(m_dn[k]));
      chk($sformatf("ovr%0d", k), int'(ov[k]), int'(m_ov[k]));
      chk($sformatf("cnt%0d", k),
          int'(k == 0 ? bc0 : bc1), m_cnt[k]);
    end
    if (prev0 == 8'hFF && bc0 == 8'h00) wrapped0 = 1;
    if (prev1 == 8'hFF && bc1 == 8'h00) wrapped1 = 1;
    prev0 = bc0;
    prev1 = bc1;
  end

  task automatic step(bit t, bit e, bit c);
    @(negedge clk);
    #1;
    trigger = t;
    en = e;
    clr_ovr = c;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 1, 0);
  endtask

  // Cycle 0 is the first driven cycle; -1 disables an event
  task automatic seq(int t1, int t2, int en_off, int clr_at, int n);
    for (int c = 0; c < n; c++)
      step(c == t1 || c == t2,
           !(en_off >= 0 && c >= en_off),
           c == clr_at);
  endtask

  logic [12:0] dp0, db0, dd0, mp0, mb0, md0;
  logic [12:0] dp1, dd1, mp1, md1;
  int cnt11;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pulse", int'(po[0]), 0);
    chk("rst_busy", int'(bs[0]), 0);
    chk("rst_cnt", int'(bc0), 0);
    step(0, 1, 0);
    reset = 1'b1;
    idle(2);

    // Basic burst, recorded cycle by cycle
    dp0 = '0; db0 = '0; dd0 = '0; mp0 = '0; mb0 = '0; md0 = '0;
    dp1 = '0; dd1 = '0; mp1 = '0; md1 = '0; cnt11 = -1;
    step(1, 1, 0);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      #1;
      dp0[i] = po[0]; db0[i] = bs[0]; dd0[i] = dn[0];
      mp0[i] = m_po[0]; mb0[i] = m_bs[0]; md0[i] = m_dn[0];
      dp1[i] = po[1]; dd1[i] = dn[1];
      mp1[i] = m_po[1]; md1[i] = m_dn[1];
      if (i == 11) cnt11 = int'(bc0);
      trigger = 0;
    end
    chk("lit_pulse_a", int'(dp0), 13'h0666);
    chk("lit_busy_a", int'(db0), 13'h07FE);
    chk("lit_done_a", int'(dd0), 13'h0800);
    chk("lit_mpulse_a", int'(mp0), 13'h0666);
    chk("lit_mbusy_a", int'(mb0), 13'h07FE);
    chk("lit_mdone_a", int'(md0), 13'h0800);
    chk("lit_cnt11", cnt11, 1);
    chk("lit_pulse_b", int'(dp1), 13'h0002);
    chk("lit_done_b", int'(dd1), 13'h0004);
    chk("lit_mpulse_b", int'(mp1), 13'h0002);
    chk("lit_mdone_b", int'(md1), 13'h0004);
    idle(4);

    // Overrun at cycle 4, then clear at 20
    seq(0, 4, -1, 20, 21);
    idle(1);
    chk("lit_ovr_clr", int'(ov[0]), 0);
    // Clear together with a dropped trigger
    seq(0, 3, -1, 3, 15);
    chk("lit_ovr_set_wins", int'(ov[0]), 1);
    seq(-1, -1, -1, 0, 2);
    // Back-to-back: second trigger in the done cycle
    seq(0, 11, -1, -1, 12);
    @(negedge clk);
    #1;
    chk("lit_b2b_pulse12", int'(po[0]), 1);
    trigger = 0;
    idle(14);
    chk("lit_b2b_novr", int'(ov[0]), 0);
    // Trigger in the last HIGH cycle is dropped
    seq(0, 10, -1, -1, 16);
    chk("lit_late_ovr", int'(ov[0]), 1);
    seq(-1, -1, -1, 0, 2);
    // en gating in IDLE, then en dropped mid-burst
    seq(0, -1, 0, -1, 4);
    chk("lit_en_busy", int'(bs[0]), 0);
    seq(0, -1, 3, -1, 14);
    idle(2);

    // Reset in cycle 6 of a burst
    seq(0, -1, -1, -1, 6);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_mid_pulse", int'(po[0]), 0);
    chk("rst_mid_busy", int'(bs[0]), 0);
    chk("rst_mid_done", int'(dn[0]), 0);
    chk("rst_mid_cnt", int'(bc0), 0);
    step(0, 1, 0);
    reset = 1'b1;
    seq(0, -1, -1, -1, 14);

    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(5) == 0,
           $urandom_range(9) != 0,
           $urandom_range(19) == 0);

    // Constant triggering until both counters wrap
    for (int i = 0; i < 3000; i++) step(1, 1, 0);
    idle(15);
    chk("wrap_a", int'(wrapped0), 1);
    chk("wrap_b", int'(wrapped1), 1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
